// File: rtl/reg_dump.sv
// Register-file dump engine: snapshots R0..R14 (+ optional PC as R15) on start
// and streams one 32-bit word per valid/ready handshake, pulsing done at the end.
module reg_dump #(
    parameter int unsigned INCLUDE_PC = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [479:0] rf_in,
    input  logic [31:0]  pc_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [3:0]   out_idx,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [3:0] LAST_IDX = (INCLUDE_PC != 0) ? 4'd15 : 4'd14;

    state_t       state_q, state_d;
    logic [511:0] snap_q, snap_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;
    logic         at_last;
    logic         xfer;
    logic         streaming;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        streaming = (state_q == STREAM);
        at_last   = (idx_q == LAST_IDX);
        xfer      = streaming && out_ready;

        case (state_q)
            IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    snap_d  = {rf_in, pc_in};
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (xfer) begin
                    if (at_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // word n of the snapshot sits at bits [511-32n -: 32]; R15 (PC) is the lowest word
    always_comb begin
        out_valid = streaming;
        busy      = streaming;
        done      = done_q;
        out_idx   = streaming ? idx_q : '0;
        out_last  = streaming && at_last;
        out_data  = streaming ? snap_q[{4'd15 - idx_q, 5'd0} +: 32] : '0;
    end

endmodule

// File: tb/tb_reg_dump.sv
// Randomized bench for reg_dump: both INCLUDE_PC variants share stimulus and are
// compared each cycle against a queue-of-expected-words reference model.
module tb_reg_dump;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
    } word_t;

    logic         clk = 1'b0;
    logic         reset, start, abort, out_ready;
    logic [479:0] rf_in;
    logic [31:0]  pc_in;

    logic        v1, l1, b1, dn1, v0, l0, b0, dn0;
    logic [31:0] d1, d0;
    logic [3:0]  i1, i0;
    logic [39:0] vec1, vec0;

    int tests_run    = 0;
    int tests_failed = 0;

    word_t q1[$];
    word_t q0[$];
    logic  done1_e, done0_e;

    always #5 clk = ~clk;

    reg_dump #(.INCLUDE_PC(1)) dut_pc (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_in(rf_in), .pc_in(pc_in), .out_valid(v1), .out_ready(out_ready),
        .out_data(d1), .out_idx(i1), .out_last(l1), .busy(b1), .done(dn1)
    );

    reg_dump #(.INCLUDE_PC(0)) dut_nopc (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rf_in(rf_in), .pc_in(pc_in), .out_valid(v0), .out_ready(out_ready),
        .out_data(d0), .out_idx(i0), .out_last(l0), .busy(b0), .done(dn0)
    );

    assign vec1 = {v1, d1, i1, l1, b1, dn1};
    assign vec0 = {v0, d0, i0, l0, b0, dn0};

    // Reference: a pending dump is the list of words still to be delivered.
    task automatic model_step(input bit pc);
        word_t q[$];
        logic  d;
        int    n;
        q = pc ? q1 : q0;
        d = 1'b0;
        if (reset) begin
            q.delete();
        end else if (q.size() > 0) begin
            if (abort) begin
                q.delete();
            end else if (out_ready) begin
                void'(q.pop_front());
                d = (q.size() == 0);
            end
        end else if (start && !abort) begin
            n = pc ? 16 : 15;
            for (int i = 0; i < n; i++) begin
                word_t w;
                w.idx  = 4'(i);
                w.data = (i == 15) ? pc_in : rf_in[479 - 32 * i -: 32];
                q.push_back(w);
            end
        end
        if (pc) begin q1 = q; done1_e = d; end
        else    begin q0 = q; done0_e = d; end
    endtask

    function automatic logic [39:0] exp_vec(input bit pc);
        word_t w;
        int    n;
        logic  d;
        n = pc ? q1.size() : q0.size();
        d = pc ? done1_e : done0_e;
        if (n == 0) return {1'b0, 32'h0, 4'h0, 1'b0, 1'b0, d};
        w = pc ? q1[0] : q0[0];
        return {1'b1, w.data, w.idx, (n == 1), 1'b1, d};
    endfunction

    task automatic tick();
        model_step(1'b1);
        model_step(1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_counting_rf();
        for (int n = 0; n < 15; n++) rf_in[479 - 32 * n -: 32] = 32'h1000_0000 + 32'(n);
        pc_in = 32'h0000_0040;
    endtask

    task automatic randomize_rf();
        for (int n = 0; n < 15; n++) rf_in[479 - 32 * n -: 32] = $urandom;
        pc_in = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        randomize_rf();
        tick();
        tick();
        tests_run++;
        if (vec1 !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_pc got=%h exp=%h", vec1, 40'h0);
        end
        tests_run++;
        if (vec0 !== exp_vec(1'b0)) begin
            tests_failed++;
            $display("FAIL reset_nopc got=%h exp=%h", vec0, exp_vec(1'b0));
        end
        reset = 1'b0; start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int xfer1, xfer0, last1, last0, dones1, dones0;
        xfer1 = 0; xfer0 = 0; last1 = -1; last0 = -1; dones1 = 0; dones0 = 0;
        set_counting_rf();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tests_run++;
            if (vec1 !== exp_vec(1'b1)) begin
                tests_failed++;
                $display("FAIL basic_pc c=%0d got=%h exp=%h", c, vec1, exp_vec(1'b1));
            end
            tests_run++;
            if (vec0 !== exp_vec(1'b0)) begin
                tests_failed++;
                $display("FAIL basic_nopc c=%0d got=%h exp=%h", c, vec0, exp_vec(1'b0));
            end
            if (v1 && out_ready) xfer1++;
            if (v0 && out_ready) xfer0++;
            if (l1) last1 = int'(i1);
            if (l0) last0 = int'(i0);
            if (dn1) dones1++;
            if (dn0) dones0++;
            tick();
        end
        tests_run++;
        if (xfer1 != 16 || xfer0 != 15) begin
            tests_failed++;
            $display("FAIL basic_count got=%0d/%0d exp=16/15", xfer1, xfer0);
        end
        tests_run++;
        if (last1 != 15 || last0 != 14) begin
            tests_failed++;
            $display("FAIL basic_last_idx got=%0d/%0d exp=15/14", last1, last0);
        end
        tests_run++;
        if (dones1 != 1 || dones0 != 1) begin
            tests_failed++;
            $display("FAIL basic_done_pulses got=%0d/%0d exp=1/1", dones1, dones0);
        end
    endtask

    task automatic test_stall_random();
        int guard;
        guard = 0;
        randomize_rf();
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while ((q1.size() > 0 || q0.size() > 0 || dn1 || dn0) && guard < 200) begin
            tests_run++;
            if (vec1 !== exp_vec(1'b1)) begin
                tests_failed++;
                $display("FAIL stall_pc g=%0d got=%h exp=%h", guard, vec1, exp_vec(1'b1));
            end
            tests_run++;
            if (vec0 !== exp_vec(1'b0)) begin
                tests_failed++;
                $display("FAIL stall_nopc g=%0d got=%h exp=%h", guard, vec0, exp_vec(1'b0));
            end
            out_ready = 1'($urandom_range(0, 1));
            randomize_rf();
            tick();
            guard++;
        end
        tests_run++;
        if (guard >= 200) begin
            tests_failed++;
            $display("FAIL stall_timeout got=%0d exp=<200", guard);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_start_ignored();
        bit pulsed, restarted, verified;
        int guard;
        pulsed = 0; restarted = 0; verified = 0; guard = 0;
        randomize_rf();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!(restarted && q1.size() == 0 && q0.size() == 0 && !dn1 && !dn0) && guard < 80) begin
            tests_run++;
            if (vec1 !== exp_vec(1'b1)) begin
                tests_failed++;
                $display("FAIL restart_pc g=%0d got=%h exp=%h", guard, vec1, exp_vec(1'b1));
            end
            tests_run++;
            if (vec0 !== exp_vec(1'b0)) begin
                tests_failed++;
                $display("FAIL restart_nopc g=%0d got=%h exp=%h", guard, vec0, exp_vec(1'b0));
            end
            if (restarted && !verified) begin
                verified = 1;
                tests_run++;
                if (!(v1 === 1'b1 && i1 === 4'd0)) begin
                    tests_failed++;
                    $display("FAIL restart_idx0 got=v%b/i%0d exp=v1/i0", v1, i1);
                end
            end
            start = 1'b0;
            if (v1 && i1 == 4'd5 && !pulsed) begin
                pulsed = 1;
                start = 1'b1;
                randomize_rf();
            end else if (dn1 && !restarted) begin
                restarted = 1;
                start = 1'b1;
                randomize_rf();
            end
            tick();
            guard++;
        end
        start = 1'b0;
        tests_run++;
        if (guard >= 80 || !verified) begin
            tests_failed++;
            $display("FAIL restart_timeout got=%0d exp=<80", guard);
        end
    endtask

    task automatic test_abort_and_reset();
        int guard;
        randomize_rf();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(v1 && i1 == 4'd7) && guard < 40) begin tick(); guard++; end
        tests_run++;
        if (guard >= 40) begin
            tests_failed++;
            $display("FAIL abort_wait got=%0d exp=<40", guard);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (vec1 !== exp_vec(1'b1) || vec1 !== 40'h0) begin
                tests_failed++;
                $display("FAIL abort_pc c=%0d got=%h exp=%h", c, vec1, 40'h0);
            end
            tests_run++;
            if (vec0 !== exp_vec(1'b0)) begin
                tests_failed++;
                $display("FAIL abort_nopc c=%0d got=%h exp=%h", c, vec0, exp_vec(1'b0));
            end
            tick();
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(v1 && i1 == 4'd3) && guard < 40) begin tick(); guard++; end
        tests_run++;
        if (guard >= 40) begin
            tests_failed++;
            $display("FAIL reset_wait got=%0d exp=<40", guard);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (vec1 !== 40'h0 || vec0 !== 40'h0) begin
                tests_failed++;
                $display("FAIL midreset c=%0d got=%h/%h exp=0", c, vec1, vec0);
            end
            tick();
        end

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tests_run++;
        if (vec1 !== exp_vec(1'b1) || vec0 !== exp_vec(1'b0)) begin
            tests_failed++;
            $display("FAIL abort_beats_start got=%h/%h exp=%h/%h",
                     vec1, vec0, exp_vec(1'b1), exp_vec(1'b0));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        rf_in = '0; pc_in = '0;
        q1.delete(); q0.delete();
        done1_e = 1'b0; done0_e = 1'b0;
        test_reset();
        test_basic();
        test_stall_random();
        test_start_ignored();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
